// File: rtl/aes_ctr_reg_resp_pkg.sv
// Shared constants and state encoding for the AES CTR counter-register responder.
package aes_ctr_reg_resp_pkg;

    localparam int unsigned aes_pkg_SliceSizeCtr  = 16;
    localparam int unsigned aes_pkg_NumSlicesCtr  = 8;
    localparam int unsigned aes_pkg_SliceIdxWidth = 3;
    localparam int unsigned CtrWidth = aes_pkg_SliceSizeCtr * aes_pkg_NumSlicesCtr;

    // Sparse encoding: every pair of legal codes differs in at least 3 bits.
    typedef enum logic [4:0] {
        IDLE  = 5'b00110,
        REQ   = 5'b11000,
        BUSY  = 5'b01011,
        ERROR = 5'b10101
    } aes_ctr_resp_e;

    function automatic logic resp_state_valid(input aes_ctr_resp_e s);
        return s inside {IDLE, REQ, BUSY, ERROR};
    endfunction

endpackage

// File: rtl/aes_ctr_reg_resp_if.sv
// Bus between the counter-register responder (slave) and its requester/FSM side (master).
interface aes_ctr_reg_resp_if;
    import aes_ctr_reg_resp_pkg::*;

    logic [CtrWidth-1:0]              iv_i;
    logic                             iv_load_i;
    logic                             step_req_i;
    logic                             step_done_o;
    logic                             busy_o;
    logic [CtrWidth-1:0]              ctr_o;
    logic                             incr_o;
    logic                             ready_i;
    logic                             fsm_alert_i;
    logic [aes_pkg_SliceIdxWidth-1:0] ctr_slice_idx_i;
    logic [aes_pkg_SliceSizeCtr-1:0]  ctr_slice_o;
    logic [aes_pkg_SliceSizeCtr-1:0]  ctr_slice_i;
    logic                             ctr_we_i;
    logic                             alert_o;

    modport master (
        output iv_i, iv_load_i, step_req_i, ready_i, fsm_alert_i,
               ctr_slice_idx_i, ctr_slice_i, ctr_we_i,
        input  step_done_o, busy_o, ctr_o, incr_o, ctr_slice_o, alert_o
    );

    modport slave (
        input  iv_i, iv_load_i, step_req_i, ready_i, fsm_alert_i,
               ctr_slice_idx_i, ctr_slice_i, ctr_we_i,
        output step_done_o, busy_o, ctr_o, incr_o, ctr_slice_o, alert_o
    );

endinterface

// File: rtl/aes_ctr_reg_resp.sv
// Holds the 128-bit CTR counter, serves slice reads/write-backs to the increment FSM,
// sequences step requests over incr/ready and raises a sticky alert on any violation.
module aes_ctr_reg_resp
    import aes_ctr_reg_resp_pkg::*;
#(
    parameter int unsigned NumSlices     = aes_pkg_NumSlicesCtr,
    parameter int unsigned TimeoutCycles = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    aes_ctr_reg_resp_if.slave  bus
);

    localparam int unsigned ExpIdxWidth = $clog2(NumSlices + 1);
    localparam int unsigned WdogWidth   = $clog2(TimeoutCycles + 1);

    aes_ctr_resp_e          state_q;
    logic [CtrWidth-1:0]    ctr_q;
    logic [ExpIdxWidth-1:0] exp_idx_q;
    logic [WdogWidth-1:0]   wdog_q;
    logic                   incr_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   alert_q;

    logic in_step;
    logic state_bad;
    logic wr_err;
    logic wdog_err;
    logic err;

    // Error detection for the current cycle; the FSM moves to ERROR on the next edge.
    always_comb begin
        in_step   = 1'b0;
        state_bad = 1'b0;
        wr_err    = 1'b0;
        wdog_err  = 1'b0;
        err       = 1'b0;

        in_step   = (state_q == REQ) || (state_q == BUSY);
        state_bad = !resp_state_valid(state_q);
        if (bus.ctr_we_i) begin
            if (state_q == IDLE) begin
                wr_err = 1'b1;
            end else if (in_step) begin
                wr_err = (exp_idx_q == ExpIdxWidth'(NumSlices)) ||
                         (ExpIdxWidth'(bus.ctr_slice_idx_i) != exp_idx_q);
            end
        end
        // Counter holds cycles already spent; this cycle is the TimeoutCycles-th one.
        wdog_err = in_step && (wdog_q == WdogWidth'(TimeoutCycles - 1));
        err      = (state_q != ERROR) &&
                   (bus.fsm_alert_i || wr_err || wdog_err || state_bad);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ctr_q     <= '0;
            exp_idx_q <= '0;
            wdog_q    <= '0;
            incr_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            alert_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (err) begin
                state_q <= ERROR;
                alert_q <= 1'b1;
                incr_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (bus.iv_load_i) begin
                            ctr_q <= bus.iv_i;
                        end
                        if (bus.step_req_i) begin
                            state_q   <= REQ;
                            incr_q    <= 1'b1;
                            busy_q    <= 1'b1;
                            exp_idx_q <= '0;
                            wdog_q    <= '0;
                        end
                    end
                    REQ, BUSY: begin
                        wdog_q <= wdog_q + WdogWidth'(1);
                        if (bus.ctr_we_i) begin
                            ctr_q[aes_pkg_SliceSizeCtr*bus.ctr_slice_idx_i +: aes_pkg_SliceSizeCtr]
                                <= bus.ctr_slice_i;
                            exp_idx_q <= exp_idx_q + ExpIdxWidth'(1);
                        end
                        if (bus.ready_i) begin
                            if (state_q == REQ) begin
                                state_q <= BUSY;
                                incr_q  <= 1'b0;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    ERROR: begin
                        alert_q <= 1'b1;
                        incr_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ERROR;
                        alert_q <= 1'b1;
                        incr_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ctr_slice_o = ctr_q[aes_pkg_SliceSizeCtr*bus.ctr_slice_idx_i +: aes_pkg_SliceSizeCtr];
    assign bus.ctr_o       = ctr_q;
    assign bus.incr_o      = incr_q;
    assign bus.busy_o      = busy_q;
    assign bus.step_done_o = done_q;
    assign bus.alert_o     = alert_q;

endmodule

// File: tb/tb_aes_ctr_reg_resp.sv
// Directed bench for aes_ctr_reg_resp: slice-read vector table plus step/error/reset sequences.
module tb_aes_ctr_reg_resp;

    logic clk_i;
    logic rst_ni;
    int   checks;
    int   failures;

    aes_ctr_reg_resp_if bus();

    aes_ctr_reg_resp dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic         load;
        logic [127:0] iv;
        logic [2:0]   idx;
        logic [15:0]  exp_slice;
        logic [127:0] exp_ctr;
    } vec_t;

    localparam logic [127:0] IVA  = 128'h1111_2222_3333_4444_5555_6666_0000_FFFF;
    localparam logic [127:0] IVA1 = 128'h1111_2222_3333_4444_5555_6666_0001_0000;
    localparam logic [127:0] IVB  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.iv_i            = '0;
        bus.iv_load_i       = 1'b0;
        bus.step_req_i      = 1'b0;
        bus.ready_i         = 1'b0;
        bus.fsm_alert_i     = 1'b0;
        bus.ctr_slice_idx_i = '0;
        bus.ctr_slice_i     = '0;
        bus.ctr_we_i        = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic wr(input logic [2:0] idx, input logic [15:0] val);
        bus.ctr_we_i        = 1'b1;
        bus.ctr_slice_idx_i = idx;
        bus.ctr_slice_i     = val;
        tick();
        bus.ctr_we_i        = 1'b0;
    endtask

    // Request a step and let the FSM accept it immediately; leaves the DUT in BUSY.
    task automatic step_to_busy();
        bus.step_req_i = 1'b1;
        tick();
        bus.step_req_i = 1'b0;
        bus.ready_i    = 1'b1;
        tick();
        bus.ready_i    = 1'b0;
    endtask

    task automatic finish_step();
        bus.ready_i = 1'b1;
        tick();
        bus.ready_i = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0] = '{1'b1, IVA, 3'd0, 16'hFFFF, IVA};
        vecs[1] = '{1'b0, '0,  3'd1, 16'h0000, IVA};
        vecs[2] = '{1'b0, '0,  3'd2, 16'h6666, IVA};
        vecs[3] = '{1'b0, '0,  3'd7, 16'h1111, IVA};
        vecs[4] = '{1'b1, IVB, 3'd3, 16'hFEDC, IVB};
        vecs[5] = '{1'b0, '0,  3'd6, 16'h4567, IVB};
        vecs[6] = '{1'b0, '0,  3'd4, 16'hCDEF, IVB};
        vecs[7] = '{1'b1, IVA, 3'd5, 16'h3333, IVA};

        rst_ni = 1'b1;
        clear_inputs();
        #1;
        rst_ni = 1'b0;
        #3;
        chk("rst_ctr",   bus.ctr_o, '0);
        chk("rst_slice", bus.ctr_slice_o, '0);
        chk("rst_incr",  bus.incr_o, '0);
        chk("rst_busy",  bus.busy_o, '0);
        chk("rst_done",  bus.step_done_o, '0);
        chk("rst_alert", bus.alert_o, '0);
        rst_ni = 1'b1;
        tick();

        // Idle loads and zero-latency slice reads
        for (int i = 0; i < 8; i++) begin
            bus.iv_load_i = vecs[i].load;
            bus.iv_i      = vecs[i].iv;
            tick();
            bus.iv_load_i       = 1'b0;
            bus.ctr_slice_idx_i = vecs[i].idx;
            #1;
            chk($sformatf("vec%0d_slice", i), bus.ctr_slice_o, vecs[i].exp_slice);
            chk($sformatf("vec%0d_ctr", i),   bus.ctr_o,       vecs[i].exp_ctr);
        end

        // Normal step: slice 0 FFFF->0000, carry into slice 1
        bus.step_req_i = 1'b1;
        tick();
        bus.step_req_i = 1'b0;
        chk("a_incr_req", bus.incr_o, 1'b1);
        chk("a_busy_req", bus.busy_o, 1'b1);
        tick();
        chk("a_incr_hold", bus.incr_o, 1'b1);
        finish_step();
        chk("a_incr_busy", bus.incr_o, 1'b0);
        chk("a_busy_busy", bus.busy_o, 1'b1);
        chk("a_done_busy", bus.step_done_o, 1'b0);
        bus.iv_load_i = 1'b1;
        bus.iv_i      = IVB;
        tick();
        bus.iv_load_i = 1'b0;
        chk("a_load_dropped", bus.ctr_o, IVA);
        wr(3'd0, 16'h0000);
        wr(3'd1, 16'h0001);
        bus.ctr_slice_idx_i = 3'd1;
        #1;
        chk("a_slice1", bus.ctr_slice_o, 16'h0001);
        chk("a_ctr", bus.ctr_o, IVA1);
        chk("a_done_pre", bus.step_done_o, 1'b0);
        finish_step();
        chk("a_done", bus.step_done_o, 1'b1);
        chk("a_busy_end", bus.busy_o, 1'b0);
        tick();
        chk("a_done_once", bus.step_done_o, 1'b0);
        chk("a_alert", bus.alert_o, 1'b0);

        // Write while idle is fatal; later load/step ignored
        wr(3'd2, 16'h5A5A);
        chk("b_alert", bus.alert_o, 1'b1);
        bus.iv_load_i  = 1'b1;
        bus.iv_i       = IVB;
        bus.step_req_i = 1'b1;
        tick();
        bus.iv_load_i  = 1'b0;
        bus.step_req_i = 1'b0;
        tick();
        chk("b_ctr_frozen", bus.ctr_o, IVA1);
        chk("b_incr", bus.incr_o, 1'b0);
        chk("b_busy", bus.busy_o, 1'b0);
        chk("b_alert_sticky", bus.alert_o, 1'b1);
        do_reset();
        chk("b_rst_alert", bus.alert_o, 1'b0);
        chk("b_rst_ctr", bus.ctr_o, '0);

        // Out-of-order write (0 then 2) is fatal and not committed
        bus.iv_load_i = 1'b1;
        bus.iv_i      = IVB;
        tick();
        bus.iv_load_i = 1'b0;
        step_to_busy();
        wr(3'd0, 16'hAAAA);
        chk("c_alert_pre", bus.alert_o, 1'b0);
        wr(3'd2, 16'hBBBB);
        chk("c_alert", bus.alert_o, 1'b1);
        chk("c_busy", bus.busy_o, 1'b0);
        bus.ctr_slice_idx_i = 3'd2;
        #1;
        chk("c_slice2", bus.ctr_slice_o, 16'hBA98);
        chk("c_ctr", bus.ctr_o, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_AAAA);
        do_reset();

        // Watchdog: ready held low after the request
        bus.step_req_i = 1'b1;
        tick();
        bus.step_req_i = 1'b0;
        for (int c = 1; c < 16; c++) tick();
        chk("d_alert_c16", bus.alert_o, 1'b0);
        chk("d_incr_c16", bus.incr_o, 1'b1);
        tick();
        chk("d_alert_c17", bus.alert_o, 1'b1);
        chk("d_incr_c17", bus.incr_o, 1'b0);
        chk("d_busy_c17", bus.busy_o, 1'b0);
        do_reset();

        // Load + step together, all-ones wraps to zero
        bus.iv_load_i  = 1'b1;
        bus.iv_i       = '1;
        bus.step_req_i = 1'b1;
        tick();
        bus.iv_load_i  = 1'b0;
        bus.step_req_i = 1'b0;
        chk("e_loaded", bus.ctr_o, {128{1'b1}});
        chk("e_incr", bus.incr_o, 1'b1);
        finish_step();
        for (int s = 0; s < 8; s++) wr(3'(s), 16'h0000);
        chk("e_ctr_wrap", bus.ctr_o, '0);
        finish_step();
        chk("e_done", bus.step_done_o, 1'b1);
        chk("e_alert", bus.alert_o, 1'b0);
        tick();

        // Ninth write in one step is fatal
        step_to_busy();
        for (int s = 0; s < 8; s++) wr(3'(s), 16'(s + 1));
        chk("f_ctr8", bus.ctr_o, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        chk("f_alert_pre", bus.alert_o, 1'b0);
        wr(3'd0, 16'hFFFF);
        chk("f_alert", bus.alert_o, 1'b1);
        chk("f_ctr_frozen", bus.ctr_o, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        do_reset();

        // Async reset while BUSY with alert raised, then a clean step
        bus.iv_load_i = 1'b1;
        bus.iv_i      = IVB;
        tick();
        bus.iv_load_i = 1'b0;
        step_to_busy();
        chk("g_busy", bus.busy_o, 1'b1);
        bus.fsm_alert_i = 1'b1;
        tick();
        bus.fsm_alert_i = 1'b0;
        chk("g_alert", bus.alert_o, 1'b1);
        bus.ctr_slice_idx_i = 3'd0;
        rst_ni = 1'b0;
        #2;
        chk("g_rst_alert", bus.alert_o, 1'b0);
        chk("g_rst_busy",  bus.busy_o, 1'b0);
        chk("g_rst_incr",  bus.incr_o, 1'b0);
        chk("g_rst_done",  bus.step_done_o, 1'b0);
        chk("g_rst_ctr",   bus.ctr_o, '0);
        chk("g_rst_slice", bus.ctr_slice_o, '0);
        rst_ni = 1'b1;
        tick();
        bus.step_req_i = 1'b1;
        tick();
        bus.step_req_i = 1'b0;
        chk("g_incr", bus.incr_o, 1'b1);
        finish_step();
        wr(3'd0, 16'h0001);
        finish_step();
        chk("g_done", bus.step_done_o, 1'b1);
        chk("g_ctr", bus.ctr_o, 128'h1);
        chk("g_alert_end", bus.alert_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_ctr_reg_resp.md
# aes_ctr_reg_resp

Counter-register responder for the AES CTR-mode slice increment. It owns the 128-bit counter value and serves the slice-wise read/write port driven by `aes_ctr_fsm`: it returns the addressed 16-bit slice and commits write-backs. It also sequences increment requests from the cipher control path over the FSM's `incr`/`ready` handshake and raises an alert on protocol violations, an FSM alert, or a stalled increment.

## Interface
- `NumSlices`, default 8: number of 16-bit counter slices (`aes_pkg_NumSlicesCtr`).
- `TimeoutCycles`, default 16: maximum number of consecutive cycles allowed in REQ+BUSY before an alert is raised.

- `clk_i`  in  1  clock. One clock domain only.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `iv_i`  in  128  counter value to load (slice 0 = bits 15:0).
- `iv_load_i`  in  1  load strobe for `iv_i`.
- `step_req_i`  in  1  request one counter increment.
- `step_done_o`  out  1  one-cycle pulse when the increment has completed.
- `busy_o`  out  1  high in REQ or BUSY.
- `ctr_o`  out  128  current counter value.
- `incr_o`  out  1  increment request to the FSM.
- `ready_i`  in  1  FSM ready/idle indication.
- `fsm_alert_i`  in  1  alert input from the FSM.
- `ctr_slice_idx_i`  in  `aes_pkg_SliceIdxWidth` (3)  slice index addressed by the FSM.
- `ctr_slice_o`  out  16  slice returned to the FSM.
- `ctr_slice_i`  in  16  slice written back by the FSM.
- `ctr_we_i`  in  1  slice write enable.
- `alert_o`  out  1  fatal alert (sticky).

## Operation
- Storage is `ctr_q[127:0]`, organised as `NumSlices` slices of 16 bits.
- Read path: `ctr_slice_o = ctr_q[16*idx +: 16]`. It is purely combinational from `ctr_slice_idx_i` and `ctr_q`.
- Write path: `ctr_we_i` in REQ or BUSY writes `ctr_slice_i` into slice `idx` at the next edge. No carry or arithmetic is done here; the FSM owns the +1 and carry propagation.
- FSM states:
  - IDLE → REQ on `step_req_i`.
  - REQ (`incr_o=1`) → BUSY when `ready_i=1`, i.e. the FSM has accepted the request.
  - BUSY (`incr_o=0`) → IDLE when `ready_i=1`, emitting a `step_done_o` pulse.
  - Any state → ERROR on any error. ERROR is terminal until reset.
- Ordering check: the `exp_idx` register is cleared on entry to REQ and increments on each accepted write. A write with `idx != exp_idx` is an error.
- A write with `exp_idx == NumSlices` (ninth write) is an error.
- `ctr_we_i` in IDLE is an error.
- `fsm_alert_i=1` in any state is an error.
- Watchdog: a cycle counter is cleared on entry to REQ. Reaching `TimeoutCycles` while in REQ or BUSY is an error.
- ERROR behaviour:
  - `alert_o=1`, `incr_o=0`, `busy_o=0`.
  - Writes, loads and requests are ignored.
  - `ctr_q` is frozen.
- Loads:
  - `iv_load_i` is accepted only in IDLE, replacing all of `ctr_q` at the next edge.
  - In REQ, BUSY or ERROR a load is silently dropped, with no alert.
- `iv_load_i` and `step_req_i` in the same IDLE cycle: the load is applied and the step is accepted. The increment therefore operates on the loaded value.
- `step_req_i` outside IDLE is ignored. The requester waits for `step_done_o` before requesting again.

## Timing
- Reset values: `ctr_q=0`, state IDLE, `exp_idx=0`, watchdog 0. All outputs 0 and `ctr_slice_o = 0`.
- Reset mid-operation: all state returns to the reset values immediately (asynchronous), including clearing ERROR.
- `incr_o` is registered. It rises the cycle after `step_req_i` and stays high until the first cycle with `ready_i=1` in REQ, inclusive.
- Slice read has zero latency. A written slice is visible on `ctr_slice_o` and `ctr_o` from the next cycle.
- `step_done_o` is registered. It pulses in the cycle after BUSY observes `ready_i=1`.
- Minimum step, with a 1-cycle FSM: request at cycle 0, `incr_o` at cycle 1, BUSY at cycle 2, done pulse at cycle 3 or later.
- `alert_o` rises the cycle after the offending event and stays high until reset.

## Structure
- The following belong in `aes_pkg`:
  - The existing constants `aes_pkg_SliceSizeCtr` (16), `aes_pkg_NumSlicesCtr` (8) and `aes_pkg_SliceIdxWidth` (3).
  - A new enum `aes_ctr_resp_e` {IDLE, REQ, BUSY, ERROR}. It uses a sparse encoding with Hamming distance ≥3; an invalid encoding maps to ERROR.
- No sub-module is needed: the slice mux, write decode, watchdog and FSM fit in a single module.
- A buffered `_p` hardening wrapper is a separate, later block.

## Test plan
- Load `iv_i=0x…0000_FFFF`, step. FSM writes slice 0 = 0x0000, then slice 1 = 0x0001 → `ctr_o=0x…0001_0000`, exactly one `step_done_o`, `alert_o=0`.
- Idle, FSM pulses `ctr_we_i` with idx 2 → `alert_o=1` next cycle. A later `iv_load_i` and `step_req_i` are ignored and `ctr_o` is unchanged.
- During BUSY, write idx 0, then idx 2 (skipping 1) → `alert_o=1`. The idx 2 slice is not written.
- Step with `ready_i` held low for 16 cycles after request → `alert_o=1` at cycle 17 and `incr_o=0`.
- `iv_load_i` together with `step_req_i` in IDLE, `iv_i` = all-ones, FSM writes all 8 slices = 0 → `ctr_o=0` (wrap-around), done pulse.
- Assert `rst_ni=0` while BUSY with `alert_o=1` → all outputs 0 and state IDLE. A fresh step then completes normally.
